picorv_mem_arbiter: RTL

PICORV_MEM_ARBITER -- requirements
Module: picorv_mem_arbiter

---
 rtl/picorv_mem_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/picorv_mem_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// picorv_mem_arbiter
//
// Two-requester arbiter for the picorv32 native memory interface. Two cores
// (or a core plus a DMA-like requester) share one downstream port, normally
// wired to picorv32_to_ahb_master_adapter.
//
// Behaviour:
//   * IDLE picks a winner among the valid requesters. Both valid: round-robin
//     against the last completed owner, or fixed priority to m0.
//   * BUSY forwards the owner's request combinationally to the shared port.
//     It waits for s_mem_ready, the owner dropping mem_valid (abort) or the
//     timeout, whichever comes first.
//   * A timeout completes the transfer towards the owner with 32'hDEAD_BEEF
//     and a one-cycle timeout_err pulse.
//   * Every grant is followed by at least one IDLE cycle.
//
// Parameters:
//   ROUND_ROBIN     1 = alternate between requesters, 0 = m0 always wins
//   TIMEOUT_CYCLES  BUSY cycles without s_mem_ready before forced completion
//                   (0 disables the timeout)
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   mN_mem_valid/instr/addr/
//         wdata/wstrb               requester N request (N = 0, 1)
//   mN_mem_ready, mN_mem_rdata      requester N completion and read data
//   s_mem_valid/instr/addr/
//         wdata/wstrb               shared downstream request
//   s_mem_ready, s_mem_rdata        shared downstream completion and data
//   grant                           current owner index, meaningful while busy
//   busy                            arbiter is in BUSY
//   timeout_err                     one-cycle pulse on a timeout completion
// -----------------------------------------------------------------------------
module picorv_mem_arbiter #(
    parameter bit         ROUND_ROBIN    = 1'b1,
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_mem_valid,
    input  logic        m0_mem_instr,
    input  logic [31:0] m0_mem_addr,
    input  logic [31:0] m0_mem_wdata,
    input  logic [3:0]  m0_mem_wstrb,
    output logic        m0_mem_ready,
    output logic [31:0] m0_mem_rdata,

    input  logic        m1_mem_valid,
    input  logic        m1_mem_instr,
    input  logic [31:0] m1_mem_addr,
    input  logic [31:0] m1_mem_wdata,
    input  logic [3:0]  m1_mem_wstrb,
    output logic        m1_mem_ready,
    output logic [31:0] m1_mem_rdata,

    output logic        s_mem_valid,
    output logic        s_mem_instr,
    output logic [31:0] s_mem_addr,
    output logic [31:0] s_mem_wdata,
    output logic [3:0]  s_mem_wstrb,
    input  logic        s_mem_ready,
    input  logic [31:0] s_mem_rdata,

    output logic        grant,
    output logic        busy,
    output logic        timeout_err
);

    localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 8'd0);
    // The counter is cleared on entry to BUSY, so the Nth BUSY cycle sees N-1.
    localparam logic [7:0]  TIMEOUT_LAST  = TIMEOUT_CYCLES - 8'd1;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t     state_reg, state_next;
    logic       owner_reg, owner_next;
    logic       last_owner_reg, last_owner_next;
    logic [7:0] count_reg, count_next;

    logic        is_busy;
    logic        winner;
    logic        own_valid;
    logic        own_instr;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic [3:0]  own_wstrb;
    logic        xfer_done;
    logic        timeout_hit;
    logic        xfer_abort;

    assign is_busy = (state_reg == ST_BUSY);

    // ------------------------------------------------------------------
    // Arbitration: only consulted in IDLE.
    // ------------------------------------------------------------------
    always_comb begin
        winner = 1'b0;
        if (m0_mem_valid && m1_mem_valid) begin
            winner = ROUND_ROBIN ? ~last_owner_reg : 1'b0;
        end else if (m1_mem_valid) begin
            winner = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Owner's request, selected by the registered owner. The non-owner's
    // inputs never reach the shared port while BUSY.
    // ------------------------------------------------------------------
    assign own_valid = owner_reg ? m1_mem_valid : m0_mem_valid;
    assign own_instr = owner_reg ? m1_mem_instr : m0_mem_instr;
    assign own_addr  = owner_reg ? m1_mem_addr  : m0_mem_addr;
    assign own_wdata = owner_reg ? m1_mem_wdata : m0_mem_wdata;
    assign own_wstrb = owner_reg ? m1_mem_wstrb : m0_mem_wstrb;

    // Normal completion takes precedence over a timeout landing on the same
    // cycle. A withdrawn request (abort) takes precedence over both, so a
    // late s_mem_ready never produces a ready the requester no longer expects.
    assign xfer_abort  = is_busy && !own_valid;
    assign xfer_done   = is_busy && own_valid && s_mem_ready;
    assign timeout_hit = TIMEOUT_EN && is_busy && own_valid && !s_mem_ready &&
                         (count_reg == TIMEOUT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            count_reg      <= 8'd0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            count_reg      <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        count_next      = count_reg;

        case (state_reg)
            ST_IDLE: begin
                // s_mem_ready is deliberately not looked at here.
                if (m0_mem_valid || m1_mem_valid) begin
                    owner_next = winner;
                    count_next = 8'd0;
                    state_next = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (xfer_abort) begin
                    // Abandoned transfer does not count as a turn.
                    state_next = ST_IDLE;
                end else if (xfer_done || timeout_hit) begin
                    last_owner_next = owner_reg;
                    state_next      = ST_IDLE;
                end else if (count_reg != 8'hFF) begin
                    // Saturate instead of wrapping so a disabled timeout
                    // never aliases back to a small count.
                    count_next = count_reg + 8'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-requester completion. Only the owner ever sees ready; the
    // DEAD_BEEF marker is steered to the owner only on a timeout, every
    // other time both requesters see the slave data directly.
    // ------------------------------------------------------------------
    logic [1:0]  req_ready;
    logic [31:0] req_rdata [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_req
            localparam logic IDX = (gi == 1);
            logic is_owner;

            assign is_owner       = is_busy && (owner_reg == IDX);
            assign req_ready[gi]  = is_owner && (xfer_done || timeout_hit);
            assign req_rdata[gi]  = (is_owner && timeout_hit) ? TIMEOUT_RDATA
                                                              : s_mem_rdata;
        end
    endgenerate

    assign m0_mem_ready = req_ready[0];
    assign m1_mem_ready = req_ready[1];
    assign m0_mem_rdata = req_rdata[0];
    assign m1_mem_rdata = req_rdata[1];

    // ------------------------------------------------------------------
    // Shared port: all zero outside BUSY; valid is withdrawn on the cycle
    // the timeout fires so the slave does not start a transfer nobody
    // will wait for.
    // ------------------------------------------------------------------
    assign s_mem_valid = is_busy && own_valid && !timeout_hit;
    assign s_mem_instr = is_busy && own_instr;
    assign s_mem_addr  = is_busy ? own_addr  : 32'd0;
    assign s_mem_wdata = is_busy ? own_wdata : 32'd0;
    assign s_mem_wstrb = is_busy ? own_wstrb : 4'd0;

    assign grant       = is_busy && owner_reg;
    assign busy        = is_busy;
    assign timeout_err = timeout_hit;

endmodule
